// File: rtl/ecg_patch_buffer_if.sv
// Bundle of sample-input and patch-output signals for ecg_patch_buffer.
// drop_cnt is present only when ECG_PATCH_DROP_CNT_EN is defined.
interface ecg_patch_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PATCH_LEN  = 15
);
    logic                         s_valid;
    logic signed [DATA_WIDTH-1:0] s_data;
    logic                         flush;
    logic signed [DATA_WIDTH-1:0] patch_o [PATCH_LEN];
    logic                         patch_valid;
    logic                         patch_ready;
    logic                         overflow;
    logic [3:0]                   fill_cnt;
`ifdef ECG_PATCH_DROP_CNT_EN
    logic [15:0]                  drop_cnt;
`endif

    // Environment side: feeds samples and consumes patches.
    modport master (
        output s_valid, s_data, flush, patch_ready,
        input  patch_o, patch_valid, overflow, fill_cnt
`ifdef ECG_PATCH_DROP_CNT_EN
        , input drop_cnt
`endif
    );

    // Buffer side.
    modport slave (
        input  s_valid, s_data, flush, patch_ready,
        output patch_o, patch_valid, overflow, fill_cnt
`ifdef ECG_PATCH_DROP_CNT_EN
        , output drop_cnt
`endif
    );
endinterface

// File: rtl/ecg_patch_buffer.sv
// Ping-pong buffer that packs serial Q4.4 ECG samples into PATCH_LEN-sample patches.
// Optional macro ECG_PATCH_DROP_CNT_EN adds a saturating 16-bit dropped-sample counter.
module ecg_patch_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int PATCH_LEN  = 15
) (
    input  logic clk,
    input  logic rst,
    ecg_patch_buffer_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, BOTH} occ_e;

    logic signed [DATA_WIDTH-1:0] bank [2][PATCH_LEN];
    logic [1:0] full;
    logic       wr_sel;
    logic       rd_sel;
    logic [3:0] wr_cnt;
    occ_e       state;
    occ_e       state_nxt;

    logic do_write;
    logic do_drop;
    logic complete;
    logic accept;

    // A full write bank only happens when both banks are full, so BOTH marks a drop.
    always_comb begin
        do_write = bus.s_valid && !bus.flush && !full[wr_sel];
        do_drop  = bus.s_valid && !bus.flush && (state == BOTH);
        complete = do_write && (wr_cnt == 4'(PATCH_LEN - 1));
        accept   = full[rd_sel] && bus.patch_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // NOTE: a default is assigned first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (complete) state_nxt = ONE;
            ONE: begin
                if (complete && !accept)      state_nxt = BOTH;
                else if (accept && !complete) state_nxt = EMPTY;
            end
            BOTH:    if (accept) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // NOTE: the sample banks are reset because patch_o must read all zeros
    // straight out of reset; otherwise data storage would be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < PATCH_LEN; i++)
                    bank[b][i] <= '0;
        end else if (do_write) begin
            bank[wr_sel][wr_cnt] <= bus.s_data;
        end
    end

    // Completion and accept always target different banks, so both may update full[].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full         <= 2'b00;
            wr_sel       <= 1'b0;
            rd_sel       <= 1'b0;
            wr_cnt       <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.overflow <= do_drop;
            if (bus.flush) begin
                wr_cnt <= '0;
            end else if (do_write) begin
                if (complete) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= ~wr_sel;
                    wr_cnt       <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 4'd1;
                end
            end
            if (accept) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PATCH_LEN; i++)
            bus.patch_o[i] = bank[rd_sel][i];
        bus.patch_valid = full[rd_sel];
        bus.fill_cnt    = wr_cnt;
    end

`ifdef ECG_PATCH_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.drop_cnt <= '0;
        else if (do_drop && bus.drop_cnt != 16'hFFFF)
            bus.drop_cnt <= bus.drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ecg_patch_buffer.sv
// Directed self-checking bench for ecg_patch_buffer; expected values are hand-computed.
module tb_ecg_patch_buffer;
    localparam int DW = 8;
    localparam int PL = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ecg_patch_buffer_if #(.DATA_WIDTH(DW), .PATCH_LEN(PL)) bus ();

    ecg_patch_buffer #(.DATA_WIDTH(DW), .PATCH_LEN(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        tick();
        bus.s_valid = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int i);
        return bus.patch_o[i];
    endfunction

    initial begin
        int seen;
        int last_cyc;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.flush       = 1'b0;
        bus.patch_ready = 1'b0;
        #12;
        check("rst_valid", 32'(bus.patch_valid), 32'd0);
        check("rst_ovf",   32'(bus.overflow),    32'd0);
        check("rst_fill",  32'(bus.fill_cnt),    32'd0);
        check("rst_p0",    32'(pat(0)),          32'd0);
        rst = 1'b0;
        tick();

        // Single patch 01..0F with no consumer.
        for (int i = 1; i <= PL; i++) begin
            push(8'(i));
            if (i == 14) begin
                check("sp_fill14",  32'(bus.fill_cnt),    32'd14);
                check("sp_valid14", 32'(bus.patch_valid), 32'd0);
            end
        end
        check("sp_valid", 32'(bus.patch_valid), 32'd1);
        check("sp_p0",    32'(pat(0)),          32'h01);
        check("sp_p14",   32'(pat(14)),         32'h0F);
        check("sp_fill",  32'(bus.fill_cnt),    32'd0);
        tick(); tick();
        check("sp_hold",  32'(bus.patch_valid), 32'd1);
        bus.patch_ready = 1'b1;
        tick();
        check("sp_acc",   32'(bus.patch_valid), 32'd0);

        // Continuous 45-sample stream with consumer always ready.
        seen = 0;
        last_cyc = 0;
        for (int c = 1; c <= 46; c++) begin
            if (c <= 45) push(8'(32 + c - 1));
            else         tick();
            check("cs_ovf", 32'(bus.overflow), 32'd0);
            if (bus.patch_valid) begin
                check("cs_p0",  32'(pat(0)),  32'(32 + 15 * seen));
                check("cs_p14", 32'(pat(14)), 32'(46 + 15 * seen));
                if (seen > 0) check("cs_gap", 32'(c - last_cyc), 32'd15);
                last_cyc = c;
                seen++;
            end
        end
        check("cs_count", 32'(seen), 32'd3);
        bus.patch_ready = 1'b0;

        // Overflow: 31 samples without consumer, banks fill after 30.
        for (int i = 0; i < 30; i++) push(8'(8'h40 + i));
        check("of_valid", 32'(bus.patch_valid), 32'd1);
        check("of_p0",    32'(pat(0)),          32'h40);
        check("of_ovf0",  32'(bus.overflow),    32'd0);
        push(8'h5E);
        check("of_ovf1",  32'(bus.overflow),    32'd1);
        check("of_fill",  32'(bus.fill_cnt),    32'd0);
        tick();
        check("of_ovf2",  32'(bus.overflow),    32'd0);
        check("of_p0_k",  32'(pat(0)),          32'h40);
`ifdef ECG_PATCH_DROP_CNT_EN
        check("of_dcnt",  32'(bus.drop_cnt),    32'd1);
`endif

        // Drain both, then completion of bank 1 coincident with accept of bank 0.
        bus.patch_ready = 1'b1;
        tick();
        check("dr_p0",    32'(pat(0)),          32'h4F);
        tick();
        check("dr_valid", 32'(bus.patch_valid), 32'd0);
        bus.patch_ready = 1'b0;
        for (int i = 0; i < PL; i++) push(8'(8'h60 + i));
        check("si_p0a",   32'(pat(0)),          32'h60);
        for (int i = 0; i < PL - 1; i++) push(8'(8'h70 + i));
        bus.patch_ready = 1'b1;
        push(8'h7E);
        bus.patch_ready = 1'b0;
        check("si_valid", 32'(bus.patch_valid), 32'd1);
        check("si_p0b",   32'(pat(0)),          32'h70);
        check("si_p14b",  32'(pat(14)),         32'h7E);
        check("si_fill",  32'(bus.fill_cnt),    32'd0);
        bus.patch_ready = 1'b1;
        tick();
        bus.patch_ready = 1'b0;
        check("si_empty", 32'(bus.patch_valid), 32'd0);

        // Flush discards a 7-sample partial patch and the coincident sample.
        for (int i = 0; i < 7; i++) push(8'(8'h11 + i));
        check("fl_fill7", 32'(bus.fill_cnt), 32'd7);
        bus.flush = 1'b1;
        push(8'h55);
        bus.flush = 1'b0;
        check("fl_fill0", 32'(bus.fill_cnt), 32'd0);
        check("fl_ovf",   32'(bus.overflow), 32'd0);
        for (int i = 0; i < PL; i++) push(8'(8'hA0 + i));
        check("fl_valid", 32'(bus.patch_valid), 32'd1);
        for (int i = 0; i < PL; i++) check("fl_pat", 32'(pat(i)), 32'(8'hA0 + i));

        // Reset with both banks full.
        for (int i = 0; i < PL; i++) push(8'(8'hC0 + i));
        check("rm_pre", 32'(bus.patch_valid), 32'd1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("rm_valid", 32'(bus.patch_valid), 32'd0);
        check("rm_fill",  32'(bus.fill_cnt),    32'd0);
        for (int i = 0; i < PL; i++) check("rm_pat", 32'(pat(i)), 32'd0);
`ifdef ECG_PATCH_DROP_CNT_EN
        check("rm_dcnt",  32'(bus.drop_cnt),    32'd0);
`endif
        tick();
        for (int i = 0; i < PL; i++) push(8'(8'h30 + i));
        check("rm_nvalid", 32'(bus.patch_valid), 32'd1);
        check("rm_np0",    32'(pat(0)),          32'h30);
        check("rm_np14",   32'(pat(14)),         32'h3E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ecg_patch_buffer.md
Name: ecg_patch_buffer

Overview:
- Upstream stage of the linear embedding block.
- Collects a serial stream of Q4.4 ECG samples into 15-sample patches and presents each patch in parallel to the embedding stage with a valid/ready handshake.
- Double-buffered (ping-pong), so the next patch can fill while the current one waits to be consumed.
- The ADC side has no backpressure. Samples arriving when both banks are full are dropped and flagged.

Parameters:
- DATA_WIDTH, 8, sample width (signed Q4.4).
- PATCH_LEN, 15, samples per patch; matches the embedding input depth.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- s_valid  input  1  sample strobe; one sample per cycle when high
- s_data  input  DATA_WIDTH (signed)  ECG sample, Q4.4
- flush  input  1  synchronous; discards the partially filled patch
- patch_o  output  DATA_WIDTH x [0:PATCH_LEN-1] (signed)  patch from the read bank; index 0 = oldest sample
- patch_valid  output  1  read bank holds a complete patch
- patch_ready  input  1  consumer accepts the patch
- overflow  output  1  one-cycle pulse when a sample is dropped
- fill_cnt  output  4  samples written into the current write bank

Behaviour:
- Storage: two banks (0/1) of PATCH_LEN registers, plus per-bank full flags full[1:0].
- Pointers: wr_sel selects the write bank; rd_sel selects the read bank; wr_cnt runs 0..PATCH_LEN-1.
- Reset: all bank registers = 0, full = 00, wr_sel = rd_sel = 0, wr_cnt = 0. patch_o = all zeros, patch_valid = 0, overflow = 0, fill_cnt = 0. Reset mid-fill discards the partial patch and any pending full banks.
- Occupancy FSM, derived from full[]:
  - EMPTY: no full bank.
  - ONE: one full bank.
  - BOTH: both banks full.
- FSM transitions:
  - EMPTY->ONE on patch completion.
  - ONE->BOTH on completion without accept.
  - ONE->EMPTY on accept without completion.
  - BOTH->ONE on accept.
  - Completion and accept in the same cycle: state unchanged.
- Write, when s_valid=1 and full[wr_sel]=0:
  - bank[wr_sel][wr_cnt] <= s_data.
  - If wr_cnt = PATCH_LEN-1: full[wr_sel] <= 1, wr_sel toggles, wr_cnt <= 0.
  - Otherwise wr_cnt increments.
- Drop: s_valid=1 while full[wr_sel]=1 (state BOTH) → sample discarded, wr_cnt unchanged, overflow=1 for the next cycle only.
- Output:
  - patch_valid = full[rd_sel], registered state.
  - patch_o = bank[rd_sel], driven directly from the registers.
- Accept: patch_valid & patch_ready at an edge → full[rd_sel] <= 0, rd_sel toggles.
- patch_o and patch_valid are held stable until accepted. patch_ready while patch_valid=0 is ignored.
- Latency: the last sample written at edge N gives patch_valid=1 from edge N onward (visible in cycle N+1), provided rd_sel points to that bank.
- Throughput: one patch per PATCH_LEN cycles sustained with patch_ready held high. The freed bank is writable in the cycle after accept.
- Simultaneous events:
  - Completion into bank A and accept of bank B in the same cycle: both take effect.
  - A write into bank X and an accept of bank X in the same cycle cannot occur, because a full bank is never written.
- Flush:
  - wr_cnt <= 0; partially written samples are not presented.
  - Full banks are retained.
  - Flush overrides a coincident s_valid write; that sample is discarded and overflow is not raised.
- fill_cnt = wr_cnt. Bank contents are not cleared on accept or flush.
- All arithmetic is unsigned on counters; wr_cnt wraps only via the completion rule.

Optional Feature:
- Macro ECG_PATCH_DROP_CNT_EN.
- Defined: adds output drop_cnt (16-bit) counting dropped samples.
  - Increments on each drop; saturates at 16'hFFFF.
  - Cleared only by rst; unaffected by flush.
- Undefined: port and counter are absent; overflow pulse behaviour is unchanged.

Test Plan:
- Single patch: s_valid high for 15 cycles, data 8'h01..8'h0F, patch_ready=0 → patch_valid rises after the 15th edge; patch_o[0]=8'h01, patch_o[14]=8'h0F; fill_cnt returns to 0.
- Continuous stream: 45 samples with patch_ready=1 → three accepted patches in order; overflow never asserted; consecutive patches separated by 15 cycles.
- Overflow: patch_ready=0, 31 samples → both banks full after 30; sample 31 dropped, overflow pulses once, fill_cnt stays 0. With ECG_PATCH_DROP_CNT_EN, drop_cnt=1.
- Simultaneous event: bank 0 full, patch_ready=1 on the same edge bank 1 completes → bank 0 accepted, bank 1 presented next cycle with patch_valid still 1, full=10.
- Flush: write 7 samples, flush=1 with s_valid=1 → fill_cnt=0; the next 15 samples form a patch containing only the new data.
- Reset mid-operation: both banks full, rst pulsed → patch_valid=0, patch_o all zero, fill_cnt=0; the next 15 samples produce a patch in bank 0.
